// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared types and widths for the voice allocator: FSM state
//               encoding, voice-index / note / stamp widths and the modular
//               age helper used when choosing a voice to steal.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int VIDX_W  = 8;
    localparam int NOTE_W  = 7;
    localparam int STAMP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Age of a voice relative to the free-running counter; the subtraction
    // wraps so ordering stays correct across a 0xFFFF -> 0 rollover.
    function automatic logic [STAMP_W-1:0] stamp_age(
        input logic [STAMP_W-1:0] now,
        input logic [STAMP_W-1:0] stamp
    );
        return now - stamp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_table.sv
`default_nettype none
// ============================================================================
// Module      : voice_table
// Description : Per-voice storage (active bit, note, and - when VOICE_STEAL_EN
//               is defined - a 16-bit age stamp). One combinational read
//               port, one synchronous write port. Active bits clear on reset.
// Ports       : i_clk, i_reset_n          clock / async active-low reset
//               i_rd_addr -> o_rd_*       read port
//               i_wr_en, i_wr_addr, i_wr_* write port
// Config      : VOICE_STEAL_EN adds the stamp storage and its port pair.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_table
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int AW         = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [AW-1:0]      i_rd_addr,
    output logic               o_rd_active,
    output logic [NOTE_W-1:0]  o_rd_note,
`ifdef VOICE_STEAL_EN
    output logic [STAMP_W-1:0] o_rd_stamp,
    input  logic [STAMP_W-1:0] i_wr_stamp,
`endif
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic               i_wr_active,
    input  logic [NOTE_W-1:0]  i_wr_note
);

    logic              r_active [NUM_VOICES];
    logic [NOTE_W-1:0] r_note   [NUM_VOICES];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_active[i] <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_active[i_wr_addr] <= i_wr_active;
        end
    end

    // Note contents are meaningless while the voice is inactive, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_note[i_wr_addr] <= i_wr_note;
        end
    end

    assign o_rd_active = r_active[i_rd_addr];
    assign o_rd_note   = r_note[i_rd_addr];

`ifdef VOICE_STEAL_EN
    logic [STAMP_W-1:0] r_stamp [NUM_VOICES];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_stamp[i_wr_addr] <= i_wr_stamp;
        end
    end

    assign o_rd_stamp = r_stamp[i_rd_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : voice_allocator
// Description : Assigns MIDI note events to a pool of NUM_VOICES voices. Each
//               accepted event is resolved by a linear scan (one voice per
//               clock), then one table write plus an o_flag strobe carrying
//               status/index/note, followed by a hold-off of UPDATE_GAP-1
//               cycles. Unresolvable events pulse o_drop instead.
// Ports       : i_clk, i_reset_n                       clock / async reset
//               i_note_valid/on/num/velocity, o_note_ready  event handshake
//               o_flag, o_note_status, o_voice_index, o_voice_note  update
//               o_drop                                 discarded-event pulse
// Config      : define VOICE_STEAL_EN to steal the oldest voice when the pool
//               is full (adds stamp storage, the "now" counter and the age
//               comparator); otherwise a full-pool note-on is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int UPDATE_GAP = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_note_valid,
    input  logic              i_note_on,
    input  logic [6:0]        i_note_num,
    input  logic [6:0]        i_note_velocity,
    output logic              o_note_ready,
    output logic              o_flag,
    output logic              o_note_status,
    output logic [7:0]        o_voice_index,
    output logic [6:0]        o_voice_note,
    output logic              o_drop
);

    localparam int                AW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);
    localparam logic [15:0]       GAP_LOAD = 16'(UPDATE_GAP - 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_flag;
    logic                r_status;
    logic [VIDX_W-1:0]   r_vidx;
    logic [NOTE_W-1:0]   r_vnote;
    logic                r_drop;

    logic [NOTE_W-1:0]   r_note;     // latched event note
    logic                r_on;       // note-on with non-zero velocity
    logic [VIDX_W-1:0]   r_scan_idx;
    logic                r_match_found;
    logic [VIDX_W-1:0]   r_match_idx;
    logic                r_free_found;
    logic [VIDX_W-1:0]   r_free_idx;
    logic [15:0]         r_gap;

    logic                w_rd_active;
    logic [NOTE_W-1:0]   w_rd_note;

    // Resolution of the scanned event, consumed in EMIT.
    logic                w_act_write;
    logic                w_act_active;
    logic                w_act_drop;
    logic [VIDX_W-1:0]   w_act_idx;

`ifdef VOICE_STEAL_EN
    logic [STAMP_W-1:0]  r_now;
    logic                r_old_found;
    logic [VIDX_W-1:0]   r_old_idx;
    logic [STAMP_W-1:0]  r_old_age;
    logic [STAMP_W-1:0]  w_rd_stamp;
    logic [STAMP_W-1:0]  w_age;

    assign w_age = stamp_age(r_now, w_rd_stamp);
`endif

    voice_table #(
        .NUM_VOICES (NUM_VOICES),
        .AW         (AW)
    ) u_table (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rd_addr   (r_scan_idx[AW-1:0]),
        .o_rd_active (w_rd_active),
        .o_rd_note   (w_rd_note),
`ifdef VOICE_STEAL_EN
        .o_rd_stamp  (w_rd_stamp),
        .i_wr_stamp  (r_now),
`endif
        .i_wr_en     ((r_state == ST_EMIT) && w_act_write),
        .i_wr_addr   (w_act_idx[AW-1:0]),
        .i_wr_active (w_act_active),
        .i_wr_note   (r_note)
    );

    always_comb begin
        w_act_write  = 1'b0;
        w_act_active = 1'b0;
        w_act_drop   = 1'b0;
        w_act_idx    = '0;
        if (r_on) begin
            if (r_match_found) begin
                w_act_write  = 1'b1;
                w_act_active = 1'b1;
                w_act_idx    = r_match_idx;
            end else if (r_free_found) begin
                w_act_write  = 1'b1;
                w_act_active = 1'b1;
                w_act_idx    = r_free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                // Pool full: every voice is active, so an oldest one exists.
                w_act_write  = 1'b1;
                w_act_active = 1'b1;
                w_act_idx    = r_old_idx;
`else
                w_act_drop   = 1'b1;
`endif
            end
        end else if (r_match_found) begin
            w_act_write  = 1'b1;
            w_act_active = 1'b0;
            w_act_idx    = r_match_idx;
        end else begin
            w_act_drop   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_ready       <= 1'b0;
            r_flag        <= 1'b0;
            r_status      <= 1'b0;
            r_vidx        <= '0;
            r_vnote       <= '0;
            r_drop        <= 1'b0;
            r_note        <= '0;
            r_on          <= 1'b0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_gap         <= '0;
`ifdef VOICE_STEAL_EN
            r_now         <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
`endif
        end else begin
            r_flag <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Ready is held low through reset and rises one clock later.
                    r_ready <= 1'b1;
                    if (i_note_valid && r_ready) begin
                        r_ready       <= 1'b0;
                        r_note        <= i_note_num;
                        r_on          <= i_note_on && (i_note_velocity != 7'd0);
                        r_scan_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
`ifdef VOICE_STEAL_EN
                        r_old_found   <= 1'b0;
                        r_old_idx     <= '0;
                        r_old_age     <= '0;
                        if (i_note_on && (i_note_velocity != 7'd0)) begin
                            r_now <= r_now + 16'd1;
                        end
`endif
                        r_state       <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_rd_active && (w_rd_note == r_note) && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!w_rd_active && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
`ifdef VOICE_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (w_rd_active && (!r_old_found || (w_age > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_scan_idx;
                        r_old_age   <= w_age;
                    end
`endif
                    if (r_scan_idx == LAST_IDX) begin
                        r_state <= ST_EMIT;
                    end else begin
                        r_scan_idx <= r_scan_idx + 8'd1;
                    end
                end
                ST_EMIT: begin
                    if (w_act_drop) begin
                        r_drop  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_flag   <= 1'b1;
                        r_status <= w_act_active;
                        r_vidx   <= w_act_idx;
                        r_vnote  <= r_note;
                        r_gap    <= GAP_LOAD;
                        r_state  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap <= 16'd1) begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_note_ready  = r_ready;
    assign o_flag        = r_flag;
    assign o_note_status = r_status;
    assign o_voice_index = r_vidx;
    assign o_voice_note  = r_vnote;
    assign o_drop        = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_allocator
// Description : Self-checking bench for voice_allocator. A table-level model
//               decides each event's outcome when it is accepted and queues
//               the expected strobe; a per-cycle compare process checks all
//               outputs. Directed scenarios pin the model with literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    localparam int N   = 16;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_note_valid = 1'b0;
    logic       i_note_on = 1'b0;
    logic [6:0] i_note_num = '0;
    logic [6:0] i_note_velocity = '0;
    logic       o_note_ready;
    logic       o_flag;
    logic       o_note_status;
    logic [7:0] o_voice_index;
    logic [6:0] o_voice_note;
    logic       o_drop;

    voice_allocator #(
        .NUM_VOICES (N),
        .UPDATE_GAP (GAP)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_note_valid    (i_note_valid),
        .i_note_on       (i_note_on),
        .i_note_num      (i_note_num),
        .i_note_velocity (i_note_velocity),
        .o_note_ready    (o_note_ready),
        .o_flag          (o_flag),
        .o_note_status   (o_note_status),
        .o_voice_index   (o_voice_index),
        .o_voice_note    (o_voice_note),
        .o_drop          (o_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit is_flag;
        int status;
        int idx;
        int note;
        int due;
    } exp_t;

    exp_t q[$];
    bit   m_active [N];
    int   m_note   [N];
    int   m_stamp  [N];
    int   m_now;
    int   ready_at;
    int   h_status, h_idx, h_note;
    int   last_acc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_active[i] = 0;
            m_note[i]   = 0;
            m_stamp[i]  = 0;
        end
        m_now = 0;
        q.delete();
        ready_at = 32'h7fffffff;
        h_status = 0;
        h_idx    = 0;
        h_note   = 0;
    endtask

    task automatic model_accept(input int acc, input bit on, input int num, input int vel);
        bit   eff_on;
        int   match, free, idx;
        exp_t e;
        eff_on   = on && (vel != 0);
        last_acc = acc;
        match = -1;
        free  = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_active[i] && m_note[i] == num) match = i;
            if (!m_active[i]) free = i;
        end
        e.due = acc + N + 1;
        if (eff_on) begin
            m_now = (m_now + 1) % 65536;
            idx = (match >= 0) ? match : free;
`ifdef VOICE_STEAL_EN
            if (idx < 0) begin
                int best;
                best = -1;
                for (int i = 0; i < N; i++) begin
                    int age;
                    age = (m_now - m_stamp[i]) & 16'hFFFF;
                    if (age > best) begin
                        best = age;
                        idx  = i;
                    end
                end
            end
`endif
            if (idx >= 0) begin
                m_active[idx] = 1;
                m_note[idx]   = num;
                m_stamp[idx]  = m_now;
                e.is_flag = 1; e.status = 1; e.idx = idx; e.note = num;
                ready_at = acc + N + GAP;
            end else begin
                e.is_flag = 0; e.status = 0; e.idx = 0; e.note = 0;
                ready_at = acc + N + 1;
            end
        end else if (match >= 0) begin
            m_active[match] = 0;
            e.is_flag = 1; e.status = 0; e.idx = match; e.note = num;
            ready_at = acc + N + GAP;
        end else begin
            e.is_flag = 0; e.status = 0; e.idx = 0; e.note = 0;
            ready_at = acc + N + 1;
        end
        q.push_back(e);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        exp_t e;
        int   ef, ed;
        if (rst_n) begin
            ef = 0;
            ed = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.is_flag) begin
                    ef = 1;
                    h_status = e.status;
                    h_idx    = e.idx;
                    h_note   = e.note;
                end else begin
                    ed = 1;
                end
            end
            check("o_flag",        int'(o_flag),        ef);
            check("o_drop",        int'(o_drop),        ed);
            check("o_note_status", int'(o_note_status), h_status);
            check("o_voice_index", int'(o_voice_index), h_idx);
            check("o_voice_note",  int'(o_voice_note),  h_note);
            check("o_note_ready",  int'(o_note_ready),  (cyc >= ready_at) ? 1 : 0);
            if (i_note_valid && o_note_ready)
                model_accept(cyc + 1, i_note_on, int'(i_note_num), int'(i_note_velocity));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit on, input int num, input int vel);
        bit done;
        @(posedge clk);
        #1;
        i_note_valid    = 1'b1;
        i_note_on       = on;
        i_note_num      = 7'(num);
        i_note_velocity = 7'(vel);
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (o_note_ready) done = 1;
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_note_valid = 1'b0;
    endtask

    task automatic wait_out(output bit got_flag, output int at, output int st,
                            output int idx, output int nt);
        got_flag = 0; at = -1; st = -1; idx = -1; nt = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (o_flag || o_drop) begin
                got_flag = o_flag;
                at  = cyc;
                st  = int'(o_note_status);
                idx = int'(o_voice_index);
                nt  = int'(o_voice_note);
                return;
            end
        end
        check("strobe_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n        = 1'b0;
        i_note_valid = 1'b0;
        model_reset();
        #1;
        check("rst_flag",   int'(o_flag),        0);
        check("rst_drop",   int'(o_drop),        0);
        check("rst_ready",  int'(o_note_ready),  0);
        check("rst_status", int'(o_note_status), 0);
        check("rst_index",  int'(o_voice_index), 0);
        check("rst_note",   int'(o_voice_note),  0);
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ready_at = cyc + 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit gf;
        int at, st, idx, nt, at1;
        model_reset();
        do_reset();

        // Single note-on: latency and first allocation.
        send(1, 60, 100);
        wait_out(gf, at, st, idx, nt);
        check("lat_first", at - last_acc, N + 1);
        check("first_flag", int'(gf), 1);
        check("first_status", st, 1);
        check("first_index", idx, 0);
        check("first_note", nt, 60);
        at1 = at;

        send(1, 64, 90);
        wait_out(gf, at, st, idx, nt);
        check("second_index", idx, 1);
        check("second_note", nt, 64);
        check("flag_spacing_ok", (at - at1 >= GAP) ? 1 : 0, 1);

        send(0, 60, 0);
        wait_out(gf, at, st, idx, nt);
        check("off_status", st, 0);
        check("off_index", idx, 0);
        check("off_note", nt, 60);

        // Velocity-0 note-on acts as note-off.
        send(1, 60, 100);
        wait_out(gf, at, st, idx, nt);
        check("realloc_index", idx, 0);
        send(1, 60, 0);
        wait_out(gf, at, st, idx, nt);
        check("vel0_status", st, 0);
        check("vel0_index", idx, 0);

        // Note-off with no owner is dropped.
        send(0, 72, 50);
        wait_out(gf, at, st, idx, nt);
        check("orphan_off_is_drop", int'(gf), 0);

        // Fill the pool, then one more.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            send(1, 10 + k, 100);
            wait_out(gf, at, st, idx, nt);
            if (k < 16) check("fill_index", idx, k);
        end
`ifdef VOICE_STEAL_EN
        check("steal_flag", int'(gf), 1);
        check("steal_index", idx, 0);
        check("steal_status", st, 1);
        check("steal_note", nt, 26);
`else
        check("full_is_drop", int'(gf), 0);
`endif

        // Reset in the middle of a scan.
        send(1, 40, 100);
        repeat (5) @(posedge clk);
        do_reset();
        repeat (30) @(posedge clk);
        send(1, 50, 100);
        wait_out(gf, at, st, idx, nt);
        check("post_reset_index", idx, 0);
        check("post_reset_note", nt, 50);

        // Randomised traffic over a small note range to force matches,
        // full-pool events and orphan note-offs.
        for (int k = 0; k < 300; k++) begin
            bit on;
            int vel;
            on  = ($urandom_range(0, 2) != 0);
            vel = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            send(on, int'($urandom_range(0, 23)), vel);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (N + GAP + 4) @(posedge clk);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 16, number of allocatable voices (2..256).
REQ-002 Parameter UPDATE_GAP, default 8, minimum clocks between successive o_flag pulses.
REQ-003 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  asynchronous active-low reset.
REQ-005 i_note_valid  in  1  note event offered.
REQ-006 i_note_on  in  1  1 = note-on, 0 = note-off.
REQ-007 i_note_num  in  7  MIDI note number.
REQ-008 i_note_velocity  in  7  MIDI velocity; 0 on a note-on means note-off.
REQ-009 o_note_ready  out  1  event accepted on the cycle where i_note_valid and o_note_ready are both 1.
REQ-010 o_flag  out  1  one-cycle update strobe to the envelope/oscillator update port.
REQ-011 o_note_status  out  1  keystate carried with o_flag (1 = key down).
REQ-012 o_voice_index  out  8  voice carried with o_flag.
REQ-013 o_voice_note  out  7  note now owned by o_voice_index, carried with o_flag.
REQ-014 o_drop  out  1  one-cycle pulse when a note-on or note-off is discarded.

Function
REQ-015 States: IDLE, SCAN, EMIT, GAP; o_note_ready is 1 only in IDLE.
REQ-016 Acceptance in IDLE latches note, on/off and velocity, clears scan results, and enters SCAN.
REQ-017 SCAN examines one voice per clock, index 0 to NUM_VOICES-1, so SCAN lasts exactly NUM_VOICES cycles.
REQ-018 Each table entry holds active (1), note (7) and stamp (16).
REQ-019 SCAN records the lowest-index active voice with matching note, the lowest-index inactive voice, and the active voice with the largest (now - stamp) mod 2^16, lowest index on ties.
REQ-020 Note-on with a matching active voice retriggers that voice.
REQ-021 Otherwise note-on takes the free voice.
REQ-022 Otherwise note-on is handled per REQ-036/REQ-037.
REQ-023 Note-off (or note-on with velocity 0) with a matching voice clears active on that voice; with no match it pulses o_drop and returns to IDLE without o_flag.
REQ-024 EMIT lasts one cycle: it writes the table, asserts o_flag with status/index/note, then enters GAP.
REQ-025 On note-on, the stamp written is the current value of the 16-bit free-running counter "now".
REQ-026 GAP holds for UPDATE_GAP-1 cycles, then returns to IDLE, so o_flag pulses are at least UPDATE_GAP cycles apart.
REQ-027 "now" increments on every accepted note-on and wraps 0xFFFF->0; age comparison uses modular subtraction only.
REQ-028 Latency: from acceptance to o_flag is NUM_VOICES+1 cycles.
REQ-029 o_status, o_voice_index and o_voice_note hold their last values between flags.
REQ-030 i_note_valid outside IDLE is not accepted; the source must hold it.

Reset
REQ-031 Assertion of i_reset_n=0 immediately clears all outputs to 0, all active bits to 0, "now" to 0, and the state to IDLE, including mid-SCAN or mid-GAP.
REQ-032 No o_flag is emitted for an event interrupted by reset.
REQ-033 o_note_ready rises on the first clock after i_reset_n deasserts.

Configuration
REQ-034 Macro VOICE_STEAL_EN selects the full-pool note-on behaviour.
REQ-035 Without VOICE_STEAL_EN, no stamp registers, age comparator or "now" counter are synthesised.
REQ-036 With VOICE_STEAL_EN, a note-on with no match and no free voice steals the oldest voice: o_flag with status 1, that index, and the new note, and a fresh stamp is written.
REQ-037 Without VOICE_STEAL_EN, such a note-on pulses o_drop, emits no o_flag, and leaves the table unchanged.

Structure
REQ-038 Shared package synth_pkg holds the state encoding, the voice-index width (8), the note width (7) and the stamp width (16).
REQ-039 Sub-module voice_table holds the per-voice active/note/stamp storage with one read port and one write port.

Verification
REQ-040 Single note-on 60 vel 100 after reset -> o_flag NUM_VOICES+1 cycles after acceptance, status 1, index 0, note 60.
REQ-041 Note-ons 60 then 64 then note-off 60 -> flags (1,0,60), (1,1,64), (0,0,60), with flags at least 8 cycles apart.
REQ-042 Note-on 60 vel 0 with voice 0 holding 60 -> flag (0,0,60).
REQ-043 Note-off 72 with no voice holding 72 -> o_drop pulse, no o_flag.
REQ-044 17 distinct note-ons with NUM_VOICES=16 -> with VOICE_STEAL_EN, 17th flag index 0, status 1, new note; without it, o_drop pulse and no flag.
REQ-045 Reset mid-SCAN -> outputs 0, no flag; a subsequent note-on allocates index 0.
